item_cfg_store: RTL and testbench

Responder side of the item configuration interface used by the vending main FSM. It holds the per-item cost and stock tables and answers item read requests with a registered cost/availability lookup. It applies dispense updates as a stock decrement. While cfg_mode is high it accepts operator writes to program cost and stock. It sits between the operator configuration path and the main FSM.

---
 rtl/vm_cfg_pkg.sv | 22 ++
 rtl/item_table.sv | 66 ++++++
 rtl/item_cfg_store.sv | 233 +++++++++++++++++++++++
 tb/tb_item_cfg_store.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_cfg_pkg.sv
// Shared definitions for the vending item configuration path: default widths,
// responder state encoding and operator write field codes.
package vm_cfg_pkg;

    localparam int unsigned NUM_ITEMS_DEF = 16;
    localparam int unsigned ID_W_DEF      = 10;
    localparam int unsigned COST_W_DEF    = 16;
    localparam int unsigned AVAIL_W_DEF   = 8;
    localparam int unsigned SOLD_W        = 16;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_UPD = 2'd1,
        ST_CFG = 2'd2
    } cfg_state_e;

    localparam logic FIELD_COST  = 1'b0;
    localparam logic FIELD_STOCK = 1'b1;

    localparam logic [COST_W_DEF-1:0] COST_INVALID = '1;

endpackage

// File: rtl/item_table.sv
// Per-item cost and stock storage: one combinational read port covering both
// fields and an independent write port per field.
module item_table import vm_cfg_pkg::*; #(
    parameter int unsigned NUM_ITEMS = NUM_ITEMS_DEF,
    parameter int unsigned ID_W      = ID_W_DEF,
    parameter int unsigned COST_W    = COST_W_DEF,
    parameter int unsigned AVAIL_W   = AVAIL_W_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [ID_W-1:0]    rd_idx,
    output logic [COST_W-1:0]  rd_cost_c,
    output logic [AVAIL_W-1:0] rd_stock_c,
    input  logic               cost_we,
    input  logic [ID_W-1:0]    cost_widx,
    input  logic [COST_W-1:0]  cost_wdata,
    input  logic               stock_we,
    input  logic [ID_W-1:0]    stock_widx,
    input  logic [AVAIL_W-1:0] stock_wdata
);

    localparam int unsigned IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int unsigned IDP_W = ID_W + 1;
    localparam logic [IDP_W-1:0] NUM_ITEMS_L = IDP_W'(NUM_ITEMS);

    logic [COST_W-1:0]  cost_q  [NUM_ITEMS];
    logic [COST_W-1:0]  cost_d  [NUM_ITEMS];
    logic [AVAIL_W-1:0] stock_q [NUM_ITEMS];
    logic [AVAIL_W-1:0] stock_d [NUM_ITEMS];
    logic               rd_hit;

    // Out-of-range reads return zero so the array is never indexed past its end
    always_comb begin
        rd_hit     = ({1'b0, rd_idx} < NUM_ITEMS_L);
        rd_cost_c  = '0;
        rd_stock_c = '0;
        if (rd_hit) begin
            rd_cost_c  = cost_q[IDX_W'(rd_idx)];
            rd_stock_c = stock_q[IDX_W'(rd_idx)];
        end
    end

    always_comb begin
        cost_d  = cost_q;
        stock_d = stock_q;
        if (cost_we) begin
            cost_d[IDX_W'(cost_widx)] = cost_wdata;
        end
        if (stock_we) begin
            stock_d[IDX_W'(stock_widx)] = stock_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NUM_ITEMS); i++) begin
                cost_q[i]  <= '0;
                stock_q[i] <= '0;
            end
        end else begin
            cost_q  <= cost_d;
            stock_q <= stock_d;
        end
    end

endmodule

// File: rtl/item_cfg_store.sv
// Item configuration responder: registered cost/stock lookup for the main FSM,
// dispense stock decrements and operator programming while in config mode.
module item_cfg_store import vm_cfg_pkg::*; #(
    parameter int unsigned NUM_ITEMS = NUM_ITEMS_DEF,
    parameter int unsigned ID_W      = ID_W_DEF,
    parameter int unsigned COST_W    = COST_W_DEF,
    parameter int unsigned AVAIL_W   = AVAIL_W_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_mode,
    input  logic               cfg_wr_valid,
    output logic               cfg_wr_ready,
    input  logic               cfg_wr_field,
    input  logic [ID_W-1:0]    cfg_wr_item,
    input  logic [COST_W-1:0]  cfg_wr_data,
    input  logic [ID_W-1:0]    cfg_item_id,
    input  logic               cfg_item_read_req,
    input  logic               cfg_item_update_req,
    output logic [COST_W-1:0]  item_cost,
    output logic [AVAIL_W-1:0] item_available,
    output logic               rd_err,
    output logic               upd_err,
    output logic [SOLD_W-1:0]  sold_total
);

    localparam int unsigned IDP_W = ID_W + 1;
    localparam logic [IDP_W-1:0] NUM_ITEMS_L = IDP_W'(NUM_ITEMS);

    cfg_state_e         state_q, state_d;
    logic [ID_W-1:0]    held_id_q, held_id_d;
    logic [ID_W-1:0]    upd_id_q, upd_id_d;
    logic               pend_q, pend_d;
    logic [ID_W-1:0]    pend_id_q, pend_id_d;
    logic [COST_W-1:0]  item_cost_q, item_cost_d;
    logic [AVAIL_W-1:0] avail_held_q, avail_held_d;
    logic [AVAIL_W-1:0] item_available_q, item_available_d;
    logic               rd_err_q, rd_err_d;
    logic [SOLD_W-1:0]  sold_total_q, sold_total_d;
    logic               cfg_wr_ready_q, cfg_wr_ready_d;

    logic [ID_W-1:0]    tbl_rd_idx;
    logic [COST_W-1:0]  tbl_cost;
    logic [AVAIL_W-1:0] tbl_stock;
    logic               cost_we, stock_we;
    logic [ID_W-1:0]    stock_widx;
    logic [AVAIL_W-1:0] stock_wdata;
    logic [AVAIL_W-1:0] stock_dec;
    logic               upd_in_range, upd_ok, upd_err_c;
    logic               lookup_en;
    logic [ID_W-1:0]    lookup_id;
    logic               wr_hit;

    function automatic logic id_ok(input logic [ID_W-1:0] id);
        return ({1'b0, id} < NUM_ITEMS_L);
    endfunction

    item_table #(
        .NUM_ITEMS (NUM_ITEMS),
        .ID_W      (ID_W),
        .COST_W    (COST_W),
        .AVAIL_W   (AVAIL_W)
    ) u_table (
        .clk         (clk),
        .rstn        (rstn),
        .rd_idx      (tbl_rd_idx),
        .rd_cost_c   (tbl_cost),
        .rd_stock_c  (tbl_stock),
        .cost_we     (cost_we),
        .cost_widx   (cfg_wr_item),
        .cost_wdata  (cfg_wr_data),
        .stock_we    (stock_we),
        .stock_widx  (stock_widx),
        .stock_wdata (stock_wdata)
    );

    always_comb begin
        state_d       = state_q;
        held_id_d     = held_id_q;
        upd_id_d      = upd_id_q;
        pend_d        = pend_q;
        pend_id_d     = pend_id_q;
        item_cost_d   = item_cost_q;
        avail_held_d  = avail_held_q;
        rd_err_d      = 1'b0;
        sold_total_d  = sold_total_q;
        tbl_rd_idx    = held_id_q;
        cost_we       = 1'b0;
        stock_we      = 1'b0;
        stock_widx    = cfg_wr_item;
        stock_wdata   = cfg_wr_data[AVAIL_W-1:0];
        stock_dec     = tbl_stock - AVAIL_W'(1);
        upd_in_range  = id_ok(upd_id_q);
        upd_ok        = 1'b0;
        upd_err_c     = 1'b0;
        lookup_en     = 1'b0;
        lookup_id     = cfg_item_id;
        wr_hit        = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (cfg_item_update_req) begin
                    state_d  = ST_UPD;
                    upd_id_d = cfg_item_id;
                end else if (cfg_mode) begin
                    state_d = ST_CFG;
                end
            end
            ST_UPD:  state_d = cfg_mode ? ST_CFG : ST_RUN;
            ST_CFG: begin
                if (!cfg_mode) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (state_q == ST_UPD) begin
            // Read port belongs to the stock read-modify-write this cycle
            tbl_rd_idx = upd_id_q;
            upd_ok     = upd_in_range && (tbl_stock != '0);
            upd_err_c  = !upd_ok;
            if (upd_ok) begin
                stock_we    = 1'b1;
                stock_widx  = upd_id_q;
                stock_wdata = stock_dec;
                if (sold_total_q != '1) begin
                    sold_total_d = sold_total_q + SOLD_W'(1);
                end
            end
            // A read issued together with the update targets the same id; answer with the new stock
            if (pend_q) begin
                pend_d    = 1'b0;
                held_id_d = upd_id_q;
                if (upd_in_range) begin
                    item_cost_d  = tbl_cost;
                    avail_held_d = upd_ok ? stock_dec : tbl_stock;
                end else begin
                    item_cost_d  = '1;
                    avail_held_d = '0;
                    rd_err_d     = 1'b1;
                end
            end else if (upd_ok && (upd_id_q == held_id_q)) begin
                avail_held_d = stock_dec;
            end
            if (cfg_item_read_req) begin
                pend_d    = 1'b1;
                pend_id_d = cfg_item_id;
            end
        end else begin
            if ((state_q == ST_RUN) && cfg_item_read_req && !cfg_item_update_req) begin
                lookup_en = 1'b1;
                lookup_id = cfg_item_id;
                pend_d    = 1'b0;
            end else if (pend_q) begin
                lookup_en = 1'b1;
                lookup_id = pend_id_q;
                pend_d    = 1'b0;
            end
            if ((state_q == ST_RUN) && cfg_item_read_req && cfg_item_update_req) begin
                pend_d    = 1'b1;
                pend_id_d = cfg_item_id;
            end
            tbl_rd_idx = lookup_id;
            if (lookup_en) begin
                held_id_d = lookup_id;
                if (id_ok(lookup_id)) begin
                    item_cost_d  = tbl_cost;
                    avail_held_d = tbl_stock;
                end else begin
                    item_cost_d  = '1;
                    avail_held_d = '0;
                    rd_err_d     = 1'b1;
                end
            end
            // Operator writes; out-of-range items are accepted but dropped
            if ((state_q == ST_CFG) && cfg_wr_valid && cfg_wr_ready_q && id_ok(cfg_wr_item)) begin
                wr_hit = (cfg_wr_item == held_id_d);
                if (cfg_wr_field == FIELD_STOCK) begin
                    stock_we = 1'b1;
                    if (wr_hit) begin
                        avail_held_d = cfg_wr_data[AVAIL_W-1:0];
                    end
                end else begin
                    cost_we = 1'b1;
                    if (wr_hit) begin
                        item_cost_d = cfg_wr_data;
                    end
                end
            end
        end

        // Stock is hidden while configuring so no dispense can be enabled
        item_available_d = (state_d == ST_CFG) ? '0 : avail_held_d;
        cfg_wr_ready_d   = (state_d == ST_CFG);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= ST_RUN;
            held_id_q        <= '0;
            upd_id_q         <= '0;
            pend_q           <= 1'b0;
            pend_id_q        <= '0;
            item_cost_q      <= '0;
            avail_held_q     <= '0;
            item_available_q <= '0;
            rd_err_q         <= 1'b0;
            sold_total_q     <= '0;
            cfg_wr_ready_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            held_id_q        <= held_id_d;
            upd_id_q         <= upd_id_d;
            pend_q           <= pend_d;
            pend_id_q        <= pend_id_d;
            item_cost_q      <= item_cost_d;
            avail_held_q     <= avail_held_d;
            item_available_q <= item_available_d;
            rd_err_q         <= rd_err_d;
            sold_total_q     <= sold_total_d;
            cfg_wr_ready_q   <= cfg_wr_ready_d;
        end
    end

    assign item_cost      = item_cost_q;
    assign item_available = item_available_q;
    assign rd_err         = rd_err_q;
    assign upd_err        = upd_err_c;
    assign sold_total     = sold_total_q;
    assign cfg_wr_ready   = cfg_wr_ready_q;

endmodule

// File: tb/tb_item_cfg_store.sv
// Scoreboard bench for item_cfg_store: expectations are queued with a due cycle
// when stimulus is driven and compared on the falling edge of that cycle.
module tb_item_cfg_store;
    import vm_cfg_pkg::*;

    localparam int NI  = 16;
    localparam int IDW = 10;
    localparam int CW  = 16;
    localparam int AW  = 8;

    localparam int K_COST   = 0;
    localparam int K_AVAIL  = 1;
    localparam int K_RDERR  = 2;
    localparam int K_UPDERR = 3;
    localparam int K_SOLD   = 4;
    localparam int K_READY  = 5;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           cfg_mode = 1'b0;
    logic           cfg_wr_valid = 1'b0;
    logic           cfg_wr_ready;
    logic           cfg_wr_field = 1'b0;
    logic [IDW-1:0] cfg_wr_item = '0;
    logic [CW-1:0]  cfg_wr_data = '0;
    logic [IDW-1:0] cfg_item_id = '0;
    logic           rd_req = 1'b0;
    logic           upd_req = 1'b0;
    logic [CW-1:0]  item_cost;
    logic [AW-1:0]  item_available;
    logic           rd_err;
    logic           upd_err;
    logic [15:0]    sold_total;

    item_cfg_store #(
        .NUM_ITEMS (NI),
        .ID_W      (IDW),
        .COST_W    (CW),
        .AVAIL_W   (AW)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .cfg_mode            (cfg_mode),
        .cfg_wr_valid        (cfg_wr_valid),
        .cfg_wr_ready        (cfg_wr_ready),
        .cfg_wr_field        (cfg_wr_field),
        .cfg_wr_item         (cfg_wr_item),
        .cfg_wr_data         (cfg_wr_data),
        .cfg_item_id         (cfg_item_id),
        .cfg_item_read_req   (rd_req),
        .cfg_item_update_req (upd_req),
        .item_cost           (item_cost),
        .item_available      (item_available),
        .rd_err              (rd_err),
        .upd_err             (upd_err),
        .sold_total          (sold_total)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          sb_due  [$];
    int          sb_kind [$];
    logic [31:0] sb_val  [$];
    string       sb_tag  [$];

    int n_tests = 0;
    int n_fail  = 0;

    int m_cost  [NI];
    int m_stock [NI];
    int m_sold  = 0;
    int hid     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observed(input int kind);
        case (kind)
            K_COST:   return 32'(item_cost);
            K_AVAIL:  return 32'(item_available);
            K_RDERR:  return 32'(rd_err);
            K_UPDERR: return 32'(upd_err);
            K_SOLD:   return 32'(sold_total);
            default:  return 32'(cfg_wr_ready);
        endcase
    endfunction

    function automatic logic [31:0] exp_cost(input int id);
        return (id < NI) ? 32'(m_cost[id]) : 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] exp_avail(input int id);
        return (id < NI) ? 32'(m_stock[id]) : 32'd0;
    endfunction

    task automatic push(input int due, input int kind, input logic [31:0] val, input string tag);
        sb_due.push_back(due);
        sb_kind.push_back(kind);
        sb_val.push_back(val);
        sb_tag.push_back(tag);
    endtask

    // Compare every expectation that falls due this cycle
    always @(negedge clk) begin
        for (int i = sb_due.size() - 1; i >= 0; i--) begin
            if (sb_due[i] == cyc) begin
                check(sb_tag[i], observed(sb_kind[i]), sb_val[i]);
                sb_due.delete(i);
                sb_kind.delete(i);
                sb_val.delete(i);
                sb_tag.delete(i);
            end
        end
    end

    task automatic clr();
        rd_req       = 1'b0;
        upd_req      = 1'b0;
        cfg_wr_valid = 1'b0;
    endtask

    task automatic do_read(input int id, input string tag);
        @(negedge clk);
        clr();
        cfg_item_id = IDW'(id);
        rd_req = 1'b1;
        hid = id;
        push(cyc + 1, K_COST,  exp_cost(id),   {tag, "_cost"});
        push(cyc + 1, K_AVAIL, exp_avail(id),  {tag, "_avail"});
        push(cyc + 1, K_RDERR, 32'(id >= NI),  {tag, "_rderr"});
        push(cyc + 2, K_RDERR, 32'd0,          {tag, "_rderr_end"});
        @(negedge clk);
        clr();
    endtask

    task automatic do_update(input int id, input logic with_read, input logic enter_cfg, input string tag);
        int  c;
        logic ok;
        @(negedge clk);
        clr();
        cfg_item_id = IDW'(id);
        upd_req = 1'b1;
        rd_req  = with_read;
        if (enter_cfg) cfg_mode = 1'b1;
        c  = cyc;
        ok = (id < NI) && (m_stock[id] > 0);
        if (ok) begin
            m_stock[id]--;
            if (m_sold < 16'hFFFF) m_sold++;
        end
        if (with_read) hid = id;
        push(c + 1, K_UPDERR, 32'(!ok),  {tag, "_upderr"});
        push(c + 1, K_READY,  32'd0,     {tag, "_ready_upd"});
        push(c + 2, K_UPDERR, 32'd0,     {tag, "_upderr_end"});
        push(c + 2, K_SOLD,   32'(m_sold), {tag, "_sold"});
        push(c + 2, K_READY,  32'(enter_cfg), {tag, "_ready_after"});
        push(c + 2, K_AVAIL,  enter_cfg ? 32'd0 : exp_avail(hid), {tag, "_avail"});
        if (with_read) begin
            push(c + 2, K_COST,  exp_cost(id),  {tag, "_cost"});
            push(c + 2, K_RDERR, 32'(id >= NI), {tag, "_rderr"});
        end
        @(negedge clk);
        clr();
    endtask

    task automatic enter_cfg_mode(input string tag);
        @(negedge clk);
        clr();
        cfg_mode = 1'b1;
        push(cyc + 1, K_READY, 32'd1, {tag, "_ready"});
        push(cyc + 1, K_AVAIL, 32'd0, {tag, "_avail_hidden"});
    endtask

    task automatic cfg_write(input logic field, input int item, input int data, input string tag);
        @(negedge clk);
        clr();
        cfg_wr_valid = 1'b1;
        cfg_wr_field = field;
        cfg_wr_item  = IDW'(item);
        cfg_wr_data  = CW'(data);
        if (item < NI) begin
            if (field == FIELD_STOCK) m_stock[item] = data & 8'hFF;
            else                      m_cost[item]  = data & 16'hFFFF;
        end
        push(cyc + 1, K_AVAIL, 32'd0,         {tag, "_avail_hidden"});
        push(cyc + 1, K_COST,  exp_cost(hid), {tag, "_cost_held"});
        push(cyc + 1, K_READY, 32'd1,         {tag, "_ready"});
    endtask

    task automatic exit_cfg_mode(input string tag);
        @(negedge clk);
        clr();
        cfg_mode = 1'b0;
        push(cyc + 1, K_READY, 32'd0,          {tag, "_ready"});
        push(cyc + 1, K_AVAIL, exp_avail(hid), {tag, "_avail_back"});
        push(cyc + 1, K_COST,  exp_cost(hid),  {tag, "_cost"});
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && sb_due.size() > 0; i++) @(negedge clk);
        check(tag, 32'(sb_due.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_cost[i]  = 0;
            m_stock[i] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cost",  32'(item_cost),      32'd0);
        check("rst_avail", 32'(item_available), 32'd0);
        check("rst_rderr", 32'(rd_err),         32'd0);
        check("rst_upderr", 32'(upd_err),       32'd0);
        check("rst_sold",  32'(sold_total),     32'd0);
        check("rst_ready", 32'(cfg_wr_ready),   32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // 1: program item 3, read it back and confirm the outputs hold
        enter_cfg_mode("t1_cfg");
        cfg_write(FIELD_COST, 3, 25, "t1_wcost");
        cfg_write(FIELD_STOCK, 3, 2, "t1_wstock");
        exit_cfg_mode("t1_exit");
        do_read(3, "t1_read");
        for (int k = 1; k <= 10; k++) begin
            push(cyc + k, K_COST,  32'd25, "t1_hold_cost");
            push(cyc + k, K_AVAIL, 32'd2,  "t1_hold_avail");
        end
        repeat (10) @(negedge clk);

        // 2: dispense down to zero, then an update on empty stock
        do_update(3, 1'b0, 1'b0, "t2_upd1");
        do_update(3, 1'b0, 1'b0, "t2_upd2");
        do_update(3, 1'b0, 1'b0, "t2_upd3");

        // 3: out-of-range read
        do_read(20, "t3_oor");

        // 4: simultaneous read and update on item 5; out-of-range write must not alias
        enter_cfg_mode("t4_cfg");
        cfg_write(FIELD_STOCK, 5, 4, "t4_wstock");
        cfg_write(FIELD_COST, 5, 40, "t4_wcost");
        cfg_write(FIELD_STOCK, 20, 7, "t4_woor");
        exit_cfg_mode("t4_exit");
        do_update(5, 1'b1, 1'b0, "t4_both");
        do_read(4, "t4_alias");
        do_read(5, "t4_reread");

        // 5: config mode raised with an update; update finishes, requests in CFG ignored
        do_update(5, 1'b0, 1'b1, "t5_upd_cfg");
        @(negedge clk);
        clr();
        cfg_item_id = IDW'(20);
        rd_req  = 1'b1;
        upd_req = 1'b1;
        push(cyc + 1, K_RDERR,  32'd0,         "t5_ign_rderr");
        push(cyc + 1, K_UPDERR, 32'd0,         "t5_ign_upderr");
        push(cyc + 1, K_COST,   exp_cost(hid), "t5_ign_cost");
        push(cyc + 1, K_AVAIL,  32'd0,         "t5_ign_avail");
        push(cyc + 1, K_READY,  32'd1,         "t5_ign_ready");
        push(cyc + 2, K_SOLD,   32'(m_sold),   "t5_ign_sold");
        @(negedge clk);
        clr();
        exit_cfg_mode("t5_exit");
        wait_drain("t5_drain");

        // 6: reset while an update is in flight
        @(negedge clk);
        clr();
        cfg_item_id = IDW'(5);
        upd_req = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        clr();
        for (int i = 0; i < NI; i++) begin
            m_cost[i]  = 0;
            m_stock[i] = 0;
        end
        m_sold = 0;
        hid    = 0;
        @(negedge clk);
        check("t6_cost",   32'(item_cost),      32'd0);
        check("t6_avail",  32'(item_available), 32'd0);
        check("t6_sold",   32'(sold_total),     32'd0);
        check("t6_upderr", 32'(upd_err),        32'd0);
        check("t6_ready",  32'(cfg_wr_ready),   32'd0);
        @(negedge clk);
        rstn = 1'b1;
        do_read(5, "t6_read");
        do_update(5, 1'b0, 1'b0, "t6_upd_empty");

        wait_drain("final_drain");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
